cordic_sincos_hs: RTL and testbench

Parametrised, handshaked successor to the single-width CORDIC sine/cosine top. It accepts an arbitrary signed fixed-point angle in degrees, reduces it modulo 360 internally, runs an iterative rotation-mode CORDIC on the first-quadrant residue and applies quadrant and sign correction. It returns gain-compensated cos/sin with a user tag over a valid/ready output that honours backpressure. It sits between the angle-generation logic and downstream DSP consumers.

---
 rtl/cordic_sincos_hs_pkg.sv | 48 ++++
 rtl/cordic_sincos_hs_if.sv | 26 ++
 rtl/cordic_sincos_hs_rot_step.sv | 22 ++
 rtl/cordic_sincos_hs.sv | 180 ++++++++++++++++++
 tb/tb_cordic_sincos_hs.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cordic_sincos_hs_pkg.sv
// Shared constants for the handshaked CORDIC sine/cosine block: state encoding,
// atan table and gain constant at 30 fractional bits, and the reduction-depth helper.
package cordic_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REDUCE = 3'd1,
        S_QUAD   = 3'd2,
        S_ROTATE = 3'd3,
        S_FIX    = 3'd4,
        S_HOLD   = 3'd5
    } state_t;

    localparam int DEG90  = 90;
    localparam int DEG360 = 360;

    // Product of cos(atan(2^-i)), scaled by 2^30.
    localparam longint K_Q30 = 64'sd652032874;

    // atan(2^-i) in degrees, scaled by 2^30.
    localparam longint ATAN_TAB [32] = '{
        64'sd48318382080, 64'sd28524006506, 64'sd15071301663, 64'sd7650428050,
        64'sd3840059795,  64'sd1921901881,  64'sd961185452,   64'sd480622056,
        64'sd240314695,   64'sd120157806,   64'sd60078960,    64'sd30039487,
        64'sd15019745,    64'sd7509872,     64'sd3754936,     64'sd1877468,
        64'sd938734,      64'sd469367,      64'sd234684,      64'sd117342,
        64'sd58671,       64'sd29335,       64'sd14668,       64'sd7334,
        64'sd3667,        64'sd1833,        64'sd917,         64'sd458,
        64'sd229,         64'sd115,         64'sd57,          64'sd29
    };

    // Round a 30-fractional-bit constant to frac fractional bits.
    function automatic longint fx_round(input longint v, input int frac);
        if (frac >= 30) return v;
        return (v + (longint'(1) << (29 - frac))) >>> (30 - frac);
    endfunction

    // One more than the largest k with 360*2^k <= 2^(width-frac-1).
    function automatic int red_steps(input int width, input int frac);
        int n;
        n = 1;
        for (int k = 1; k < 48; k++)
            if ((longint'(DEG360) << k) <= (longint'(1) << (width - frac - 1)))
                n = k + 1;
        return n;
    endfunction

endpackage

// File: rtl/cordic_sincos_hs_if.sv
// Angle-in / cos-sin-out handshake bundle. in_valid/in_ready and out_valid/out_ready
// are strict valid/ready pairs: a beat transfers on a rising edge where both are high.
interface cordic_sincos_hs_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_theta;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_cos;
    logic [WIDTH-1:0] out_sin;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid, in_theta, in_tag, out_ready,
        output in_ready, out_valid, out_cos, out_sin, out_tag
    );

    modport master (
        output in_valid, in_theta, in_tag, out_ready,
        input  in_ready, out_valid, out_cos, out_sin, out_tag
    );
endinterface

// File: rtl/cordic_sincos_hs_rot_step.sv
// One combinational rotation-mode CORDIC micro-rotation with a run-time shift amount.
module cordic_rot_step
    import cordic_pkg::*;
#(
    parameter int W   = 34,
    parameter int SHW = 8
) (
    input  logic signed [W-1:0]   i_x,
    input  logic signed [W-1:0]   i_y,
    input  logic        [SHW-1:0] i_shift,
    input  logic                  i_neg_dir,
    output logic signed [W-1:0]   o_x,
    output logic signed [W-1:0]   o_y
);
    logic signed [W-1:0] w_xs;
    logic signed [W-1:0] w_ys;

    assign w_xs = i_x >>> i_shift;
    assign w_ys = i_y >>> i_shift;
    assign o_x  = i_neg_dir ? (i_x + w_ys) : (i_x - w_ys);
    assign o_y  = i_neg_dir ? (i_y - w_xs) : (i_y + w_xs);
endmodule

// File: rtl/cordic_sincos_hs.sv
// Iterative CORDIC sine/cosine: modulo-360 reduction, first-quadrant rotation,
// quadrant/sign fix-up and clamping, with a tagged valid/ready result port.
module cordic_sincos_hs
    import cordic_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16,
    parameter int ITER  = 16,
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    cordic_sincos_hs_if.slave bus,
    output state_t            o_state
);
    localparam int RED_STEPS = red_steps(WIDTH, FRAC);
    localparam int CNT_W     = 8;
    localparam int XW        = WIDTH + 2;

    localparam logic [WIDTH:0] D90  = (WIDTH+1)'(longint'(DEG90) << FRAC);
    localparam logic [WIDTH:0] D180 = (WIDTH+1)'(longint'(2 * DEG90) << FRAC);
    localparam logic [WIDTH:0] D270 = (WIDTH+1)'(longint'(3 * DEG90) << FRAC);
    localparam logic [WIDTH:0] D360 = (WIDTH+1)'(longint'(DEG360) << FRAC);

    localparam logic signed [XW-1:0] K_FX = XW'(fx_round(K_Q30, FRAC));
    localparam logic signed [XW-1:0] ONE  = XW'(longint'(1) << FRAC);

    state_t r_state, w_next;

    logic                    r_rdy_en;
    logic                    r_neg;
    logic [TAG_W-1:0]        r_tag;
    logic [WIDTH:0]          r_r;
    logic [CNT_W-1:0]        r_cnt;
    logic [1:0]              r_q;
    logic signed [XW-1:0]    r_x, r_y;
    logic signed [WIDTH-1:0] r_z;
    logic [WIDTH-1:0]        r_cos, r_sin;
    logic [TAG_W-1:0]        r_out_tag;
    logic                    r_out_valid;

    logic                    w_in_ready;
    logic                    w_accept;
    logic [WIDTH:0]          w_theta_ext;
    logic [WIDTH:0]          w_abs;
    logic [WIDTH:0]          w_red;
    logic [1:0]              w_q;
    logic [WIDTH-1:0]        w_z;
    logic signed [WIDTH-1:0] w_atan;
    logic signed [XW-1:0]    w_xn, w_yn;
    logic signed [XW-1:0]    w_c, w_s;

    function automatic logic [WIDTH-1:0] sat(input logic signed [XW-1:0] v);
        if (v > ONE)  return ONE[WIDTH-1:0];
        if (v < -ONE) return WIDTH'(-ONE);
        return v[WIDTH-1:0];
    endfunction

    assign w_in_ready  = (r_state == S_IDLE) && r_rdy_en;
    assign w_accept    = bus.in_valid && w_in_ready;
    // Sign-extend before negating so the most negative angle stays exact.
    assign w_theta_ext = {bus.in_theta[WIDTH-1], bus.in_theta};
    assign w_abs       = bus.in_theta[WIDTH-1] ? -w_theta_ext : w_theta_ext;
    assign w_red       = D360 << r_cnt;
    assign w_atan      = WIDTH'(fx_round(ATAN_TAB[r_cnt[4:0]], FRAC));

    always_comb begin
        w_q = 2'd0;
        w_z = r_r[WIDTH-1:0];
        if (r_r >= D270) begin
            w_q = 2'd3;
            w_z = r_r[WIDTH-1:0] - D270[WIDTH-1:0];
        end else if (r_r >= D180) begin
            w_q = 2'd2;
            w_z = r_r[WIDTH-1:0] - D180[WIDTH-1:0];
        end else if (r_r >= D90) begin
            w_q = 2'd1;
            w_z = r_r[WIDTH-1:0] - D90[WIDTH-1:0];
        end
    end

    cordic_rot_step #(.W(XW), .SHW(CNT_W)) u_step (
        .i_x      (r_x),
        .i_y      (r_y),
        .i_shift  (r_cnt),
        .i_neg_dir(r_z[WIDTH-1]),
        .o_x      (w_xn),
        .o_y      (w_yn)
    );

    always_comb begin
        w_c = r_x;
        w_s = r_y;
        unique case (r_q)
            2'd1:    begin w_c = -r_y; w_s =  r_x; end
            2'd2:    begin w_c = -r_x; w_s = -r_y; end
            2'd3:    begin w_c =  r_y; w_s = -r_x; end
            default: ;
        endcase
        if (r_neg) w_s = -w_s;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (w_accept) w_next = S_REDUCE;
            S_REDUCE: if (r_cnt == '0) w_next = S_QUAD;
            S_QUAD:   w_next = S_ROTATE;
            S_ROTATE: if (r_cnt == CNT_W'(ITER - 1)) w_next = S_FIX;
            S_FIX:    w_next = S_HOLD;
            S_HOLD:   if (bus.out_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdy_en    <= 1'b0;
            r_neg       <= 1'b0;
            r_tag       <= '0;
            r_r         <= '0;
            r_cnt       <= '0;
            r_q         <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_cos       <= '0;
            r_sin       <= '0;
            r_out_tag   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            unique case (r_state)
                S_IDLE: if (w_accept) begin
                    r_tag <= bus.in_tag;
                    r_neg <= bus.in_theta[WIDTH-1];
                    r_r   <= w_abs;
                    r_cnt <= CNT_W'(RED_STEPS - 1);
                end
                S_REDUCE: begin
                    if (r_r >= w_red) r_r <= r_r - w_red;
                    r_cnt <= r_cnt - 1'b1;
                end
                S_QUAD: begin
                    r_q   <= w_q;
                    r_z   <= w_z;
                    r_x   <= K_FX;
                    r_y   <= '0;
                    r_cnt <= '0;
                end
                S_ROTATE: begin
                    r_x   <= w_xn;
                    r_y   <= w_yn;
                    r_z   <= r_z[WIDTH-1] ? (r_z + w_atan) : (r_z - w_atan);
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    r_cos       <= sat(w_c);
                    r_sin       <= sat(w_s);
                    r_out_tag   <= r_tag;
                    r_out_valid <= 1'b1;
                end
                S_HOLD: if (bus.out_ready) r_out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_cos   = r_cos;
    assign bus.out_sin   = r_sin;
    assign bus.out_tag   = r_out_tag;
    assign o_state       = r_state;
endmodule

// File: tb/tb_cordic_sincos_hs.sv
// Bench for cordic_sincos_hs: directed angles, random angles against a real-valued
// sin/cos model, backpressure, mid-operation reset and back-to-back throughput.
module tb_cordic_sincos_hs;
  import cordic_pkg::*;

  localparam int  W   = 32;
  localparam int  TW  = 4;
  localparam int  LAT = 26;
  localparam int  TOL = 6;
  localparam real PI  = 3.14159265358979323846;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t dbg_state;
  int     checks = 0;
  int     failures = 0;
  logic [TW+W-1:0] exp_q[$];

  cordic_sincos_hs_if #(.WIDTH(W), .TAG_W(TW)) bus ();

  cordic_sincos_hs #(.WIDTH(W), .FRAC(16), .ITER(16), .TAG_W(TW)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .o_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Ideal result: angle in degrees through real sin/cos, scaled to 16 fractional bits.
  function automatic int model_trig(input logic [W-1:0] th, input bit want_sin);
    real rad, v;
    rad = $itor($signed(th)) / 65536.0 * PI / 180.0;
    v = (want_sin ? $sin(rad) : $cos(rad)) * 65536.0;
    return $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
  endfunction

  task automatic drive_accept(input logic [W-1:0] th, input logic [TW-1:0] tg, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    bus.in_theta = th;
    bus.in_tag   = tg;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 60 && !ok; n++) begin
      if (bus.in_ready === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat, output bit ok);
    ok  = 1'b0;
    lat = 0;
    for (int n = 1; n <= 200 && !ok; n++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        ok  = 1'b1;
        lat = n;
      end
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    checks++;
    if (bus.out_cos !== '0 || bus.out_sin !== '0 || bus.out_tag !== '0) begin
      failures++;
      $display("FAIL reset_outputs: cos=%h sin=%h tag=%h want all zero", bus.out_cos, bus.out_sin, bus.out_tag);
    end
    checks++;
    if (dbg_state !== S_IDLE) begin
      failures++; $display("FAIL reset_state: got %0d want %0d", dbg_state, S_IDLE);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] th_tab [6];
    bit ok, rok;
    int lat, c, s, ec, es;
    th_tab = '{32'h001E0000, 32'hFFE20000, 32'h005A0000, 32'h00B40000, 32'h01C20000, 32'h80000000};
    for (int i = 0; i < 6; i++) begin
      drive_accept(th_tab[i], TW'(i + 3), ok);
      checks++;
      if (!ok) begin
        failures++; $display("FAIL dir_accept[%0d]: in_ready never rose", i);
      end
      wait_result(lat, rok);
      checks++;
      if (!rok || lat != LAT) begin
        failures++; $display("FAIL dir_latency[%0d]: got %0d (seen=%0d) want %0d", i, lat, rok, LAT);
      end
      c  = $signed(bus.out_cos);
      s  = $signed(bus.out_sin);
      ec = model_trig(th_tab[i], 1'b0);
      es = model_trig(th_tab[i], 1'b1);
      checks++;
      if (c - ec > TOL || ec - c > TOL) begin
        failures++; $display("FAIL dir_cos[%0d] theta=%h: got %0d want %0d+-%0d", i, th_tab[i], c, ec, TOL);
      end
      checks++;
      if (s - es > TOL || es - s > TOL) begin
        failures++; $display("FAIL dir_sin[%0d] theta=%h: got %0d want %0d+-%0d", i, th_tab[i], s, es, TOL);
      end
      checks++;
      if (bus.out_tag !== TW'(i + 3)) begin
        failures++; $display("FAIL dir_tag[%0d]: got %0d want %0d", i, bus.out_tag, i + 3);
      end
      consume();
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL dir_release[%0d]: out_valid=%b in_ready=%b want 0/1", i, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0]  th;
    logic [TW-1:0] tg;
    bit ok, rok;
    int lat, c, s, ec, es, dly;
    for (int i = 0; i < 24; i++) begin
      th = $urandom();
      tg = TW'($urandom_range(0, 15));
      drive_accept(th, tg, ok);
      exp_q.push_back({tg, th});
      wait_result(lat, rok);
      checks++;
      if (!ok || !rok || lat != LAT) begin
        failures++; $display("FAIL rnd_latency[%0d]: got %0d (acc=%0d seen=%0d) want %0d", i, lat, ok, rok, LAT);
      end
      dly = $urandom_range(0, 3);
      repeat (dly) @(negedge clk);
      {tg, th} = exp_q.pop_front();
      c  = $signed(bus.out_cos);
      s  = $signed(bus.out_sin);
      ec = model_trig(th, 1'b0);
      es = model_trig(th, 1'b1);
      checks++;
      if (c - ec > TOL || ec - c > TOL || s - es > TOL || es - s > TOL || bus.out_tag !== tg) begin
        failures++;
        $display("FAIL rnd_result[%0d] theta=%h: got cos=%0d sin=%0d tag=%0d want cos=%0d sin=%0d tag=%0d (+-%0d)",
                 i, th, c, s, bus.out_tag, ec, es, tg, TOL);
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] c0, s0;
    bit ok, rok;
    int lat, ec, es, bad, seen;
    drive_accept(32'h002D0000, 4'd5, ok);
    wait_result(lat, rok);
    checks++;
    if (!ok || !rok) begin
      failures++; $display("FAIL bp_result: accept=%0d seen=%0d want 1/1", ok, rok);
    end
    c0 = bus.out_cos;
    s0 = bus.out_sin;
    ec = model_trig(32'h002D0000, 1'b0);
    es = model_trig(32'h002D0000, 1'b1);
    checks++;
    if ($signed(c0) - ec > TOL || ec - $signed(c0) > TOL || $signed(s0) - es > TOL || es - $signed(s0) > TOL) begin
      failures++; $display("FAIL bp_value: got cos=%0d sin=%0d want %0d/%0d", $signed(c0), $signed(s0), ec, es);
    end
    bad = 0;
    bus.in_theta = 32'h00100000;
    bus.in_tag   = 4'd12;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.out_cos !== c0 || bus.out_sin !== s0 ||
          bus.out_tag !== 4'd5 || bus.in_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL bp_hold_stable: %0d unstable cycles, want 0", bad);
    end
    bus.in_valid = 1'b0;
    consume();
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release: out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++; $display("FAIL bp_ignored_request: out_valid high %0d cycles, want 0", seen);
    end
  endtask

  task automatic test_reset_mid();
    bit ok, rok;
    int lat, seen, c, s, ec, es;
    drive_accept(32'h001E0000, 4'd9, ok);
    repeat (12) @(negedge clk);
    checks++;
    if (dbg_state !== S_ROTATE) begin
      failures++; $display("FAIL mid_state: got %0d want %0d", dbg_state, S_ROTATE);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || dbg_state !== S_IDLE) begin
      failures++;
      $display("FAIL mid_reset: out_valid=%b in_ready=%b state=%0d want 0/0/%0d",
               bus.out_valid, bus.in_ready, dbg_state, S_IDLE);
    end
    rst = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++; $display("FAIL mid_stale: out_valid high %0d cycles, want 0", seen);
    end
    drive_accept(32'h003C0000, 4'hA, ok);
    wait_result(lat, rok);
    c  = $signed(bus.out_cos);
    s  = $signed(bus.out_sin);
    ec = model_trig(32'h003C0000, 1'b0);
    es = model_trig(32'h003C0000, 1'b1);
    checks++;
    if (!ok || !rok || lat != LAT) begin
      failures++; $display("FAIL mid_new_latency: got %0d want %0d", lat, LAT);
    end
    checks++;
    if (c - ec > TOL || ec - c > TOL || s - es > TOL || es - s > TOL || bus.out_tag !== 4'hA) begin
      failures++;
      $display("FAIL mid_new_result: got cos=%0d sin=%0d tag=%0d want %0d/%0d/10", c, s, bus.out_tag, ec, es);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0]  th;
    logic [TW-1:0] tg;
    int cyc, n_acc, n_res, last_acc, gap_bad, res_bad, c, s, ec, es;
    cyc = 0; n_acc = 0; n_res = 0; last_acc = -1; gap_bad = 0; res_bad = 0;
    exp_q.delete();
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_theta  = $urandom();
    bus.in_tag    = TW'($urandom_range(0, 15));
    bus.in_valid  = 1'b1;
    while ((n_acc < 4 || n_res < 4) && cyc < 400) begin
      if (bus.out_valid === 1'b1) begin
        n_res++;
        if (exp_q.size() == 0) res_bad++;
        else begin
          {tg, th} = exp_q.pop_front();
          c  = $signed(bus.out_cos);
          s  = $signed(bus.out_sin);
          ec = model_trig(th, 1'b0);
          es = model_trig(th, 1'b1);
          if (c - ec > TOL || ec - c > TOL || s - es > TOL || es - s > TOL || bus.out_tag !== tg) res_bad++;
        end
      end
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
        exp_q.push_back({bus.in_tag, bus.in_theta});
        if (last_acc >= 0 && cyc - last_acc != LAT + 1) gap_bad++;
        last_acc = cyc;
        n_acc++;
        @(posedge clk);
        #1;
        if (n_acc < 4) begin
          bus.in_theta = $urandom();
          bus.in_tag   = TW'($urandom_range(0, 15));
        end else bus.in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checks++;
    if (n_acc != 4 || n_res != 4) begin
      failures++; $display("FAIL b2b_count: accepts=%0d results=%0d want 4/4", n_acc, n_res);
    end
    checks++;
    if (gap_bad != 0) begin
      failures++; $display("FAIL b2b_spacing: %0d accept gaps differ from %0d cycles", gap_bad, LAT + 1);
    end
    checks++;
    if (res_bad != 0) begin
      failures++; $display("FAIL b2b_results: %0d results wrong, want 0", res_bad);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_theta  = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
